// File: rtl/timer_pkg.sv
// Shared types and digit limits for the BCD countdown timer datapath.
package timer_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned TIME_W     = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t SEC_TENS_MAX = 4'd5;
    localparam bcd_digit_t UNITS_MAX    = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // HH:MM:SS as six BCD digits, d5 = hour tens ... d0 = second units
    typedef struct packed {
        bcd_digit_t d5;
        bcd_digit_t d4;
        bcd_digit_t d3;
        bcd_digit_t d2;
        bcd_digit_t d1;
        bcd_digit_t d0;
    } time_bcd_t;

    function automatic logic load_legal(input time_bcd_t t, input int unsigned hour_max);
        int unsigned hour;
        hour = 32'(t.d5) * 32'd10 + 32'(t.d4);
        return (t.d0 <= UNITS_MAX) && (t.d1 <= SEC_TENS_MAX) &&
               (t.d2 <= UNITS_MAX) && (t.d3 <= SEC_TENS_MAX) &&
               (t.d4 <= UNITS_MAX) && (hour <= hour_max);
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: wraps 0 -> limit and raises borrow on that wrap.
module bcd_down_digit
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec,
    input  bcd_digit_t limit,
    input  logic       load,
    input  bcd_digit_t load_value,
    input  logic       clear,
    output bcd_digit_t value,
    output logic       borrow
);

    assign borrow = dec && (value == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (dec) begin
            value <= (value == '0) ? limit : value - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer with preset, start/pause/clear, done pulse and alarm.
// Optional build macro AUTO_RELOAD_EN: reload from preset on reaching zero and keep running.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned HOUR_MAX      = 23,
    parameter int unsigned AUTO_PERIOD_W = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_d5,
    input  logic [3:0] load_d4,
    input  logic [3:0] load_d3,
    input  logic [3:0] load_d2,
    input  logic [3:0] load_d1,
    input  logic [3:0] load_d0,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] d5,
    output logic [3:0] d4,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       done,
    output logic       alarm,
    output logic       load_err
);

    state_t    state, state_next;
    time_bcd_t ld_t, preset;
    logic      reload_pend, pend_next;
    logic      preset_wr, err_next, done_next, alarm_next, tick_dec;
    logic      reload_c, dig_load, count_one;

    bcd_digit_t [NUM_DIGITS-1:0] cnt, lim, ld_val;
    logic       [NUM_DIGITS-1:0] dec, borrow;

    // Reload-count width is reserved; no reload counter is built yet.
    logic [AUTO_PERIOD_W-1:0] unused_period;
    logic                     unused_borrow;
    assign unused_period = '0;
    assign unused_borrow = borrow[NUM_DIGITS-1];

    assign ld_t      = {load_d5, load_d4, load_d3, load_d2, load_d1, load_d0};
    assign count_one = (cnt == TIME_W'(1));
    assign reload_c  = reload_pend && !clear;
    assign dig_load  = preset_wr || reload_c;
    assign ld_val    = reload_c ? preset : ld_t;
    assign lim       = {DIGIT_W'(HOUR_MAX / 10), UNITS_MAX, SEC_TENS_MAX,
                        UNITS_MAX, SEC_TENS_MAX, UNITS_MAX};
    assign dec       = {borrow[NUM_DIGITS-2:0], tick_dec};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk       (clk),
            .rst_n     (rst_n),
            .dec       (dec[i]),
            .limit     (lim[i]),
            .load      (dig_load),
            .load_value(ld_val[i]),
            .clear     (clear),
            .value     (cnt[i]),
            .borrow    (borrow[i])
        );
    end

    assign {d5, d4, d3, d2, d1, d0} = cnt;

    // Control decode in priority order clear > load > start > pause > tick;
    // a control that has no effect in the current state falls through.
    always_comb begin
        state_next = state;
        alarm_next = alarm;
        preset_wr  = 1'b0;
        err_next   = 1'b0;
        done_next  = 1'b0;
        pend_next  = 1'b0;
        tick_dec   = 1'b0;
        if (clear) begin
            state_next = ST_IDLE;
            alarm_next = 1'b0;
        end else if (load && state != ST_RUN) begin
            if (load_legal(ld_t, HOUR_MAX)) begin
                preset_wr  = 1'b1;
                state_next = ST_IDLE;
                alarm_next = 1'b0;
            end else begin
                err_next = 1'b1;
            end
        end else if (start && state != ST_RUN) begin
            if (state == ST_DONE) begin
                state_next = ST_IDLE;
                alarm_next = 1'b0;
            end else if (cnt != '0) begin
                state_next = ST_RUN;
            end
        end else if (state == ST_RUN && pause) begin
            state_next = ST_PAUSE;
        end else if (state == ST_RUN && tick && !reload_pend) begin
            tick_dec = 1'b1;
            if (count_one) begin
                done_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (preset != '0) begin
                    pend_next = 1'b1;
                end else begin
                    state_next = ST_DONE;
                    alarm_next = 1'b1;
                end
`else
                state_next = ST_DONE;
                alarm_next = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            preset      <= '0;
            reload_pend <= 1'b0;
            running     <= 1'b0;
            done        <= 1'b0;
            alarm       <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state       <= state_next;
            reload_pend <= pend_next;
            running     <= (state_next == ST_RUN);
            done        <= done_next;
            alarm       <= alarm_next;
            load_err    <= err_next;
            if (preset_wr) begin
                preset <= ld_t;
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios plus random traffic against a seconds-based model.
module tb_bcd_countdown_timer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
    logic [23:0] ld = '0;
    logic [3:0]  d5, d4, d3, d2, d1, d0;
    logic        running, done, alarm, load_err;
    logic [23:0] dig;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    assign dig   = {d5, d4, d3, d2, d1, d0};
    assign flags = {running, done, alarm, load_err};

    always #5 clk = ~clk;

    bcd_countdown_timer #(.HOUR_MAX(23), .AUTO_PERIOD_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .clear(clear), .load(load),
        .load_d5(ld[23:20]), .load_d4(ld[19:16]), .load_d3(ld[15:12]),
        .load_d2(ld[11:8]), .load_d1(ld[7:4]), .load_d0(ld[3:0]),
        .start(start), .pause(pause),
        .d5(d5), .d4(d4), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .running(running), .done(done), .alarm(alarm), .load_err(load_err)
    );

    // One clock with the given controls held; returns 1ns after the edge.
    task automatic cycle(input logic c, input logic l, input logic s, input logic p, input logic t);
        clear = c; load = l; start = s; pause = p; tick = t;
        @(posedge clk); #1;
        clear = 0; load = 0; start = 0; pause = 0; tick = 0;
    endtask

    task automatic do_load(input logic [23:0] v);
        ld = v;
        cycle(0, 1, 0, 0, 0);
    endtask

    // ---------------- reference model in plain seconds ----------------
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_st, m_cnt, m_preset;
    bit m_alarm, m_done, m_err, m_pend;

    function automatic logic [23:0] sec_to_bcd(input int s);
        int h, m, x;
        h = s / 3600; m = (s / 60) % 60; x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int bcd_to_sec(input logic [23:0] v);
        return (int'(v[23:20]) * 10 + int'(v[19:16])) * 3600 +
               (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 +
               int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_legal(input logic [23:0] v);
        int n[6];
        for (int i = 0; i < 6; i++) n[i] = int'(v[4*i +: 4]);
        return n[0] <= 9 && n[1] <= 5 && n[2] <= 9 && n[3] <= 5 && n[4] <= 9 &&
               (n[5] * 10 + n[4]) <= 23;
    endfunction

    task automatic model_step();
        bit was_pend;
        was_pend = m_pend;
        m_done = 0; m_err = 0; m_pend = 0;
        if (clear) begin
            m_st = M_IDLE; m_cnt = 0; m_alarm = 0;
        end else begin
            if (was_pend) m_cnt = m_preset;
            if (load && m_st != M_RUN) begin
                if (bcd_legal(ld)) begin
                    m_cnt = bcd_to_sec(ld); m_preset = m_cnt; m_st = M_IDLE; m_alarm = 0;
                end else m_err = 1;
            end else if (start && m_st != M_RUN) begin
                if (m_st == M_DONE) begin
                    m_st = M_IDLE; m_alarm = 0;
                end else if (m_cnt != 0) m_st = M_RUN;
            end else if (m_st == M_RUN && pause) begin
                m_st = M_PAUSE;
            end else if (m_st == M_RUN && tick && !was_pend) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1;
`ifdef AUTO_RELOAD_EN
                    if (m_preset != 0) m_pend = 1;
                    else begin m_st = M_DONE; m_alarm = 1; end
`else
                    m_st = M_DONE; m_alarm = 1;
`endif
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #12;
        checks++; if (dig !== 24'h0) begin errors++; $display("FAIL reset_digits got %h exp 000000", dig); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
        @(posedge clk); #1; rst_n = 1'b1;
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h0 || flags !== 4'b0000) begin
            errors++; $display("FAIL reset_idle_tick got %h/%b exp 000000/0000", dig, flags); end
    endtask

    task automatic test_countdown();
        cycle(1, 0, 0, 0, 0);
        do_load(24'h000003);
        checks++; if (dig !== 24'h000003 || flags !== 4'b0000) begin
            errors++; $display("FAIL cd_load got %h/%b exp 000003/0000", dig, flags); end
        cycle(0, 0, 1, 0, 0);
        checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL cd_start got %b exp 1000", flags); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000002) begin errors++; $display("FAIL cd_tick1 got %h exp 000002", dig); end
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000001 || flags !== 4'b1000) begin
            errors++; $display("FAIL cd_tick2 got %h/%b exp 000001/1000", dig, flags); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000000 || flags !== 4'b0110) begin
            errors++; $display("FAIL cd_terminal got %h/%b exp 000000/0110", dig, flags); end
        cycle(0, 0, 0, 0, 1);
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL cd_done_once got %b exp 0010", flags); end
        cycle(0, 0, 1, 0, 0);
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL cd_ack got %b exp 0000", flags); end
    endtask

    task automatic test_borrow();
        cycle(1, 0, 0, 0, 0);
        do_load(24'h010000);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h005959 || flags !== 4'b1000) begin
            errors++; $display("FAIL borrow got %h/%b exp 005959/1000", dig, flags); end
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic test_pause();
        do_load(24'h000010);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000008) begin errors++; $display("FAIL pause_pre got %h exp 000008", dig); end
        cycle(0, 0, 0, 1, 1);
        checks++; if (dig !== 24'h000008 || flags !== 4'b0000) begin
            errors++; $display("FAIL pause_tick got %h/%b exp 000008/0000", dig, flags); end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000008) begin errors++; $display("FAIL pause_hold got %h exp 000008", dig); end
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000007 || flags !== 4'b1000) begin
            errors++; $display("FAIL pause_resume got %h/%b exp 000007/1000", dig, flags); end
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic test_load_err();
        do_load(24'h000005);
        do_load(24'h000060);
        checks++; if (dig !== 24'h000005 || flags !== 4'b0001) begin
            errors++; $display("FAIL err_sec got %h/%b exp 000005/0001", dig, flags); end
        cycle(0, 0, 0, 0, 0);
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL err_pulse got %b exp 0000", flags); end
        do_load(24'h240000);
        checks++; if (dig !== 24'h000005 || flags !== 4'b0001) begin
            errors++; $display("FAIL err_hour got %h/%b exp 000005/0001", dig, flags); end
        do_load(24'h235959);
        checks++; if (dig !== 24'h235959 || flags !== 4'b0000) begin
            errors++; $display("FAIL max_legal got %h/%b exp 235959/0000", dig, flags); end
        do_load(24'h000005);
        cycle(0, 0, 1, 0, 0);
        do_load(24'h000009);
        checks++; if (dig !== 24'h000005 || flags !== 4'b1000) begin
            errors++; $display("FAIL load_in_run got %h/%b exp 000005/1000", dig, flags); end
        cycle(1, 0, 0, 0, 0);
    endtask

    task automatic test_zero_and_clear();
        cycle(0, 0, 1, 0, 0);
        checks++; if (dig !== 24'h0 || flags !== 4'b0000) begin
            errors++; $display("FAIL zero_start got %h/%b exp 000000/0000", dig, flags); end
        do_load(24'h000500);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 1);
        checks++; if (dig !== 24'h0 || flags !== 4'b0000) begin
            errors++; $display("FAIL clear_run got %h/%b exp 000000/0000", dig, flags); end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        logic [23:0] exp_d[7];
        logic [3:0]  exp_f[7];
        logic        tk[7];
        exp_d = '{24'h1, 24'h0, 24'h2, 24'h1, 24'h0, 24'h2, 24'h1};
        exp_f = '{4'b1000, 4'b1100, 4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b1000};
        tk    = '{1, 1, 0, 1, 1, 0, 1};
        cycle(1, 0, 0, 0, 0);
        do_load(24'h000002);
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0, tk[i]);
            checks++; if (dig !== exp_d[i] || flags !== exp_f[i]) begin
                errors++; $display("FAIL auto_step%0d got %h/%b exp %h/%b", i, dig, flags, exp_d[i], exp_f[i]); end
        end
        cycle(1, 0, 0, 0, 0);
    endtask
`endif

    task automatic test_async_reset();
        do_load(24'h000050);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1);
        checks++; if (dig !== 24'h000049) begin errors++; $display("FAIL ar_pre got %h exp 000049", dig); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dig !== 24'h0 || flags !== 4'b0000) begin
            errors++; $display("FAIL ar_async got %h/%b exp 000000/0000", dig, flags); end
        cycle(0, 0, 1, 0, 1);
        checks++; if (dig !== 24'h0 || flags !== 4'b0000) begin
            errors++; $display("FAIL ar_held got %h/%b exp 000000/0000", dig, flags); end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [23:0] v;
        int r;
        for (int n = 0; n < 2000; n++) begin
            clear = (n == 0) || ($urandom_range(0, 99) < 2);
            load  = (n == 1) || ($urandom_range(0, 99) < 6);
            start = $urandom_range(0, 99) < 15;
            pause = $urandom_range(0, 99) < 4;
            tick  = $urandom_range(0, 99) < 50;
            r = int'($urandom_range(0, 9));
            if (n == 1) v = 24'h000003;
            else if (r < 6) v = sec_to_bcd(int'($urandom_range(0, 40)));
            else if (r < 8) v = sec_to_bcd(int'($urandom_range(0, 23 * 3600 + 3599)));
            else v = 24'($urandom);
            ld = v;
            model_step();
            @(posedge clk); #1;
            clear = 0; load = 0; start = 0; pause = 0; tick = 0;
            checks++; if (dig !== sec_to_bcd(m_cnt)) begin
                errors++; $display("FAIL rnd_digits@%0d got %h exp %h", n, dig, sec_to_bcd(m_cnt)); end
            checks++; if (running !== (m_st == M_RUN)) begin
                errors++; $display("FAIL rnd_running@%0d got %b exp %b", n, running, m_st == M_RUN); end
            checks++; if (done !== m_done) begin
                errors++; $display("FAIL rnd_done@%0d got %b exp %b", n, done, m_done); end
            checks++; if (alarm !== m_alarm) begin
                errors++; $display("FAIL rnd_alarm@%0d got %b exp %b", n, alarm, m_alarm); end
            checks++; if (load_err !== m_err) begin
                errors++; $display("FAIL rnd_load_err@%0d got %b exp %b", n, load_err, m_err); end
        end
    endtask

    initial begin
        m_st = M_IDLE; m_cnt = 0; m_preset = 0;
        m_alarm = 0; m_done = 0; m_err = 0; m_pend = 0;
        test_reset();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_countdown();
`endif
        test_borrow();
        test_pause();
        test_load_err();
        test_zero_and_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
